// File: rtl/signal_extension_unit_if.sv
// ============================================================================
// Module      : signal_extension_unit_if
// Description : Operand bus for the immediate-extension block (request/result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signal_extension_unit_if #(
  parameter int i_NBITS = 11,
  parameter int o_NBITS = 16
);
  logic               i_valid;
  logic [i_NBITS-1:0] i_signal;
  logic [1:0]         i_mode;
  logic [o_NBITS-1:0] o_signal;
  logic               o_valid;

  modport master (
    output i_valid,
    output i_signal,
    output i_mode,
    input  o_signal,
    input  o_valid
  );

  modport slave (
    input  i_valid,
    input  i_signal,
    input  i_mode,
    output o_signal,
    output o_valid
  );
endinterface

`default_nettype wire

// File: rtl/signal_extension_unit.sv
// ============================================================================
// Module      : signal_extension_unit
// Description : Registered sign/zero/shifted-sign/upper immediate extension.
//               SIGNAL_EXTENSION_SHIFT_EN enables the shift-by-2 mode (2'b10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_extension_unit #(
  parameter int i_NBITS = 11,
  parameter int e_NBITS = 5,
  parameter int o_NBITS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  signal_extension_unit_if.slave bus
);

  localparam logic [1:0] c_MODE_SEXT  = 2'b00;
  localparam logic [1:0] c_MODE_ZEXT  = 2'b01;
  localparam logic [1:0] c_MODE_SHIFT = 2'b10;
  localparam logic [1:0] c_MODE_UPPER = 2'b11;

  if (o_NBITS != i_NBITS + e_NBITS) begin : g_err_width
    $error("signal_extension_unit: o_NBITS must equal i_NBITS + e_NBITS");
  end
  if (i_NBITS < 1) begin : g_err_inbits
    $error("signal_extension_unit: i_NBITS must be at least 1");
  end
  if (e_NBITS < 2) begin : g_err_ebits
    $error("signal_extension_unit: e_NBITS must be at least 2");
  end

  logic               w_sign;
  logic [o_NBITS-1:0] w_sext;
  logic [o_NBITS-1:0] w_zext;
  logic [o_NBITS-1:0] w_shift;
  logic [o_NBITS-1:0] w_upper;
  logic [o_NBITS-1:0] w_result;
  logic [o_NBITS-1:0] r_signal;
  logic               r_valid;

  assign w_sign  = bus.i_signal[i_NBITS-1];
  assign w_sext  = {{e_NBITS{w_sign}}, bus.i_signal};
  assign w_zext  = {{e_NBITS{1'b0}}, bus.i_signal};
  assign w_upper = {bus.i_signal, {e_NBITS{1'b0}}};

`ifdef SIGNAL_EXTENSION_SHIFT_EN
  // The two dropped MSBs are sign copies since e_NBITS >= 2.
  assign w_shift = {w_sext[o_NBITS-3:0], 2'b00};
`else
  assign w_shift = w_sext;
`endif

  always_comb begin
    w_result = w_sext;
    case (bus.i_mode)
      c_MODE_SEXT:  w_result = w_sext;
      c_MODE_ZEXT:  w_result = w_zext;
      c_MODE_SHIFT: w_result = w_shift;
      c_MODE_UPPER: w_result = w_upper;
      default:      w_result = w_sext;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_signal <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_signal <= w_result;
      end
    end
  end

  assign bus.o_signal = r_signal;
  assign bus.o_valid  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_signal_extension_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized traffic against an arithmetic reference model.
`default_nettype none

module tb_signal_extension_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  signal_extension_unit_if #(.i_NBITS(11), .o_NBITS(16)) bus ();

  signal_extension_unit #(
    .i_NBITS(11),
    .e_NBITS(5),
    .o_NBITS(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] sig;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then observe 1 ns after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [10:0] s, input logic [1:0] m);
    @(negedge clk);
    rst          = r;
    bus.i_valid  = v;
    bus.i_signal = s;
    bus.i_mode   = m;
    @(posedge clk);
    #1;
  endtask

  // Reference: treat the field as a signed/unsigned integer and scale it.
  function automatic logic [15:0] ref_ext(input logic [10:0] s, input logic [1:0] m);
    int sv;
    int uv;
    uv = int'(s);
    sv = s[10] ? uv - 2048 : uv;
    case (m)
      2'd0:    return 16'(sv);
      2'd1:    return 16'(uv);
`ifdef SIGNAL_EXTENSION_SHIFT_EN
      2'd2:    return 16'(sv * 4);
`else
      2'd2:    return 16'(sv);
`endif
      default: return 16'(uv * 32);
    endcase
  endfunction

  initial begin
    logic [15:0] exp_sig;
    logic        exp_val;
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_signal = 11'h7FF;
    bus.i_mode   = 2'b00;

    vecs[0]  = '{11'h000, 2'b00, 16'h0000};
    vecs[1]  = '{11'h2AA, 2'b00, 16'h02AA};
    vecs[2]  = '{11'h7AA, 2'b00, 16'hFFAA};
    vecs[3]  = '{11'h02A, 2'b00, 16'h002A};
    vecs[4]  = '{11'h7FF, 2'b00, 16'hFFFF};
    vecs[5]  = '{11'h7FF, 2'b01, 16'h07FF};
    vecs[6]  = '{11'h7AA, 2'b01, 16'h07AA};
`ifdef SIGNAL_EXTENSION_SHIFT_EN
    vecs[7]  = '{11'h2AA, 2'b10, 16'h0AA8};
    vecs[8]  = '{11'h7FF, 2'b10, 16'hFFFC};
`else
    vecs[7]  = '{11'h2AA, 2'b10, 16'h02AA};
    vecs[8]  = '{11'h7FF, 2'b10, 16'hFFFF};
`endif
    vecs[9]  = '{11'h7FF, 2'b11, 16'hFFE0};
    vecs[10] = '{11'h001, 2'b11, 16'h0020};

    // Reset held with valid asserted: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 11'h7FF, 2'b00);
      check("reset_signal", bus.o_signal, 16'h0000);
      check("reset_valid", {15'd0, bus.o_valid}, 16'h0001 & 16'h0000);
    end

    // Back-to-back table vectors; first one is also the first post-reset input.
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].sig, vecs[i].mode);
      check($sformatf("vec%0d_signal", i), bus.o_signal, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {15'd0, bus.o_valid}, 16'h0001);
    end

    // Hold during idle cycles while the input field keeps changing.
    step(1'b0, 1'b1, 11'h2AA, 2'b00);
    check("idle_load", bus.o_signal, 16'h02AA);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 11'(11'h155 + i * 11'h123), 2'(i));
      check("idle_hold_signal", bus.o_signal, 16'h02AA);
      check("idle_hold_valid", {15'd0, bus.o_valid}, 16'h0000);
    end

    // Reset mid-stream discards the in-flight input, then recovery in one cycle.
    step(1'b0, 1'b1, 11'h7AA, 2'b00);
    check("pre_reset", bus.o_signal, 16'hFFAA);
    step(1'b1, 1'b1, 11'h2AA, 2'b00);
    check("mid_reset_signal", bus.o_signal, 16'h0000);
    check("mid_reset_valid", {15'd0, bus.o_valid}, 16'h0000);
    step(1'b0, 1'b1, 11'h001, 2'b11);
    check("post_reset_signal", bus.o_signal, 16'h0020);
    check("post_reset_valid", {15'd0, bus.o_valid}, 16'h0001);

    // Randomized traffic against the reference model.
    exp_sig = 16'h0020;
    exp_val = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        v;
      logic [10:0] s;
      logic [1:0]  m;
      r = ($urandom_range(0, 24) == 0);
      v = 1'($urandom_range(0, 3) != 0);
      s = 11'($urandom);
      m = 2'($urandom);
      step(r, v, s, m);
      if (r) begin
        exp_sig = 16'h0000;
        exp_val = 1'b0;
      end else begin
        exp_val = v;
        if (v) exp_sig = ref_ext(s, m);
      end
      check("rand_signal", bus.o_signal, exp_sig);
      check("rand_valid", {15'd0, bus.o_valid}, {15'd0, exp_val});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
